// File: rtl/ram_pkg.sv
// Shared definitions for the ram block and its DMA initiator.
// Holds the default ram geometry, the DMA mode encodings and the DMA state type.
// No logic, so no latency and no backpressure.
package ram_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 13;
    localparam int DEFAULT_DATA_WIDTH = 64;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CHECK      = 3'd1,
        ST_RD_ADDR    = 3'd2,
        ST_RD_CAPTURE = 3'd3,
        ST_WR         = 3'd4,
        ST_FINISH     = 3'd5
    } dma_state_t;

endpackage

// File: rtl/ram_dma_initiator.sv
// Block COPY/FILL engine that masters the single-port ram while busy is high.
// Latency: done pulses 2 cycles after start for range error or length 0, else 2+len (FILL) or 2+3*len (COPY).
// Backpressure: none; start is ignored while busy, abort drops to IDLE and gates ram_write in the same cycle.
//
// Ports: clock/reset_n; start, mode, src_addr, dst_addr, length, fill_value (latched on start);
//        abort; busy, done, error, words_done status; ram_address/ram_in/ram_write to the ram,
//        ram_out from the ram (valid one cycle after a read address).
module ram_dma_initiator
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int MEMORY_WORDS = 6000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [DATA_WIDTH-1:0] fill_value,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_done,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_in,
    output logic                  ram_write,
    input  logic [DATA_WIDTH-1:0] ram_out
);

    localparam logic [ADDR_WIDTH+1:0] MEM_LIMIT = (ADDR_WIDTH+2)'(MEMORY_WORDS);
    localparam logic [ADDR_WIDTH:0]   ONE       = (ADDR_WIDTH+1)'(1);

    dma_state_t             state;
    logic                   mode_q;
    logic [ADDR_WIDTH-1:0]  src_q;
    logic [ADDR_WIDTH-1:0]  dst_q;
    logic [ADDR_WIDTH:0]    len_q;
    logic [DATA_WIDTH-1:0]  fill_q;
    logic                   wr_q;
    logic                   done_q;
    logic                   error_q;

    // Range ends are formed two bits wider than an address so they cannot wrap.
    logic [ADDR_WIDTH+1:0]  dst_end;
    logic [ADDR_WIDTH+1:0]  src_end;
    logic                   range_bad;
    logic [ADDR_WIDTH:0]    cnt_inc;

    assign dst_end   = {2'b00, dst_q} + {1'b0, len_q};
    assign src_end   = {2'b00, src_q} + {1'b0, len_q};
    assign range_bad = (dst_end > MEM_LIMIT) || ((mode_q == MODE_COPY) && (src_end > MEM_LIMIT));
    assign cnt_inc   = words_done + ONE;

    // abort must stop a write on the very edge it is seen, so the registered
    // strobes are qualified combinationally; they are only ever set outside IDLE.
    assign ram_write = wr_q & ~abort;
    assign done      = done_q & ~abort;
    assign error     = error_q & ~abort;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            mode_q      <= MODE_COPY;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            fill_q      <= '0;
            wr_q        <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            busy        <= 1'b0;
            words_done  <= '0;
            ram_address <= '0;
            ram_in      <= '0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (abort && (state != ST_IDLE)) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                wr_q  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            mode_q     <= mode;
                            src_q      <= src_addr;
                            dst_q      <= dst_addr;
                            len_q      <= length;
                            fill_q     <= fill_value;
                            words_done <= '0;
                            busy       <= 1'b1;
                            state      <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (range_bad) begin
                            state   <= ST_FINISH;
                            done_q  <= 1'b1;
                            error_q <= 1'b1;
                        end else if (len_q == '0) begin
                            state  <= ST_FINISH;
                            done_q <= 1'b1;
                        end else if (mode_q == MODE_COPY) begin
                            state       <= ST_RD_ADDR;
                            ram_address <= src_q;
                        end else begin
                            state       <= ST_WR;
                            ram_address <= dst_q;
                            ram_in      <= fill_q;
                            wr_q        <= 1'b1;
                        end
                    end
                    ST_RD_ADDR: begin
                        // Read address is on the pins this cycle; data returns next cycle.
                        state <= ST_RD_CAPTURE;
                    end
                    ST_RD_CAPTURE: begin
                        // ram_in doubles as the captured-data register for the write.
                        ram_in      <= ram_out;
                        ram_address <= dst_q + words_done[ADDR_WIDTH-1:0];
                        wr_q        <= 1'b1;
                        state       <= ST_WR;
                    end
                    ST_WR: begin
                        words_done <= cnt_inc;
                        if (cnt_inc == len_q) begin
                            state  <= ST_FINISH;
                            wr_q   <= 1'b0;
                            done_q <= 1'b1;
                        end else if (mode_q == MODE_COPY) begin
                            state       <= ST_RD_ADDR;
                            wr_q        <= 1'b0;
                            ram_address <= src_q + cnt_inc[ADDR_WIDTH-1:0];
                        end else begin
                            ram_address <= dst_q + cnt_inc[ADDR_WIDTH-1:0];
                        end
                    end
                    ST_FINISH: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        wr_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
